// File: rtl/vmem_scanner_pkg.sv
// vscan_pkg: shared types and constants for the video memory scanner.
//   vscan_state_e : scanner FSM state
//   WORD_BITS     : width of one video memory word (one row of pixels)
//   COL_BITS      : column index width (32 columns per row)
//   ROW_BITS      : row index width (up to 128 rows)
//   ADDR_BITS     : byte address width of the video read port
package vscan_pkg;

   localparam int unsigned WORD_BITS = 32;
   localparam int unsigned COL_BITS  = 5;
   localparam int unsigned ROW_BITS  = 7;
   localparam int unsigned ADDR_BITS = 9;
   localparam int unsigned BCNT_BITS = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StShift = 2'd2,
      StBlank = 2'd3
   } vscan_state_e;

endpackage

// File: rtl/vmem_scanner_if.sv
// vmem_scanner_if: video read port plus pixel stream of the scanner.
//   vaddr/vdata        : combinational word read from video memory
//   pix_valid/ready    : pixel stream handshake
//   pix_data/row/col   : current pixel and its coordinates
//   pix_eol            : last pixel of a row
//   frame_start/done   : frame boundary pulses
// master = scanner side, slave = memory + display sink side.
interface vmem_scanner_if;
   import vscan_pkg::*;

   logic [ADDR_BITS-1:0] vaddr;
   logic [WORD_BITS-1:0] vdata;
   logic                 pix_valid;
   logic                 pix_ready;
   logic                 pix_data;
   logic [ROW_BITS-1:0]  pix_row;
   logic [COL_BITS-1:0]  pix_col;
   logic                 pix_eol;
   logic                 frame_start;
   logic                 frame_done;

   modport master (
      output vaddr,
      input  vdata,
      output pix_valid,
      input  pix_ready,
      output pix_data,
      output pix_row,
      output pix_col,
      output pix_eol,
      output frame_start,
      output frame_done
   );

   modport slave (
      input  vaddr,
      output vdata,
      input  pix_valid,
      output pix_ready,
      input  pix_data,
      input  pix_row,
      input  pix_col,
      input  pix_eol,
      input  frame_start,
      input  frame_done
   );

endinterface

// File: rtl/vmem_scanner_shiftreg.sv
// vscan_shiftreg: 32-bit load/shift-left register, async active-high reset.
//   clk, reset : clock and asynchronous reset (clears to 0)
//   load_i     : capture din_i (has priority over shift_i)
//   shift_i    : shift left by one, zero fill
//   din_i      : parallel load data
//   q_o        : register contents; q_o[MSB] is the current pixel
module vscan_shiftreg
   import vscan_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic                 shift_i,
   input  logic [WORD_BITS-1:0] din_i,
   output logic [WORD_BITS-1:0] q_o
);

   logic [WORD_BITS-1:0] shreg_q, shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (load_i) begin
         shreg_d = din_i;
      end else if (shift_i) begin
         shreg_d = {shreg_q[WORD_BITS-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign q_o = shreg_q;

endmodule

// File: rtl/vmem_scanner.sv
// vmem_scanner: reads a 1-bit-per-pixel frame from video memory, one 32-bit
// word per row, and streams it out pixel by pixel over a valid/ready port.
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-high reset, aborts any frame in progress
//   enable : permits a new frame (looked at only in IDLE and at end of BLANK)
//   bus    : video read port + pixel stream (vmem_scanner_if.master)
// Parameters: BASE (byte address of row 0), ROWS (rows per frame),
// BLANK (idle cycles after each frame).
module vmem_scanner
   import vscan_pkg::*;
#(
   parameter logic [ADDR_BITS-1:0] BASE  = 9'h000,
   parameter int unsigned          ROWS  = 32,
   parameter int unsigned          BLANK = 16
) (
   input logic            clk,
   input logic            reset,
   input logic            enable,
   vmem_scanner_if.master bus
);

   vscan_state_e         state_q, state_d;
   logic [ROW_BITS-1:0]  row_q, row_d;
   logic [COL_BITS-1:0]  col_q, col_d;
   logic [ADDR_BITS-1:0] vaddr_q, vaddr_d;
   logic [BCNT_BITS-1:0] blank_cnt_q, blank_cnt_d;
   logic                 frame_start_q, frame_start_d;
   logic                 frame_done_q, frame_done_d;
   logic [WORD_BITS-1:0] shreg;
   logic                 xfer;
   logic                 last_col;
   logic                 last_row;

   assign xfer     = (state_q == StShift) && bus.pix_ready;
   assign last_col = (col_q == '1);
   assign last_row = (row_q == ROW_BITS'(ROWS - 1));

   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      col_d         = col_q;
      vaddr_d       = vaddr_q;
      blank_cnt_d   = blank_cnt_q;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d       = StFetch;
               row_d         = '0;
               frame_start_d = 1'b1;
            end
         end
         StFetch: begin
            state_d = StShift;
            col_d   = '0;
         end
         StShift: begin
            if (xfer) begin
               // 5-bit column wraps to 0 after col 31
               col_d = col_q + COL_BITS'(1);
               if (last_col) begin
                  if (last_row) begin
                     state_d      = StBlank;
                     row_d        = '0;
                     blank_cnt_d  = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     state_d = StFetch;
                     row_d   = row_q + ROW_BITS'(1);
                  end
               end
            end
         end
         StBlank: begin
            if (blank_cnt_q == BCNT_BITS'(BLANK - 1)) begin
               blank_cnt_d = '0;
               if (enable) begin
                  state_d       = StFetch;
                  row_d         = '0;
                  frame_start_d = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               blank_cnt_d = blank_cnt_q + BCNT_BITS'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // vdata is combinational from vaddr, so the address is registered on
      // entry to FETCH and is already stable for the whole FETCH cycle.
      if (state_d == StFetch) begin
         vaddr_d = BASE + {row_d, 2'b00};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         row_q         <= '0;
         col_q         <= '0;
         vaddr_q       <= BASE;
         blank_cnt_q   <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         vaddr_q       <= vaddr_d;
         blank_cnt_q   <= blank_cnt_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
      end
   end

   vscan_shiftreg u_shiftreg (
      .clk     (clk),
      .reset   (reset),
      .load_i  (state_q == StFetch),
      .shift_i (xfer),
      .din_i   (bus.vdata),
      .q_o     (shreg)
   );

   assign bus.vaddr       = vaddr_q;
   assign bus.pix_valid   = (state_q == StShift);
   assign bus.pix_data    = shreg[WORD_BITS-1];
   assign bus.pix_row     = row_q;
   assign bus.pix_col     = col_q;
   assign bus.pix_eol     = (state_q == StShift) && last_col;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_done  = frame_done_q;

endmodule
